mike_wayed_data_array: RTL

Multi-way cache data store with byte-masked CPU writes, a registered read port, write-first forwarding and a burst line-fill engine. It replaces the single-way combinational-read data array in the pipelined cache. It sits between the cache control FSM, which drives CPU reads and writes, and the memory adapter, which streams line fills as `s_beat`-wide beats.

---
 rtl/mike_cache_pkg.sv | 27 ++
 rtl/mike_data_bank.sv | 30 +++
 rtl/mike_wayed_data_array.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mike_cache_pkg.sv
// Shared definitions for the wayed cache data array.
// Provides the controller state encoding and helpers that derive line widths
// from the log2 line-size parameter.
package mike_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Plain-vector state constants used by the controller register.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_CLEAR = CLEAR;

  // Bytes per line.
  function automatic int unsigned mask_bits(input int unsigned offset);
    return 32'(1) << offset;
  endfunction

  // Bits per line.
  function automatic int unsigned line_bits(input int unsigned offset);
    return 8 * mask_bits(offset);
  endfunction

endpackage

// File: rtl/mike_data_bank.sv
// One way of the data array: num_sets lines with per-byte write enables and a
// combinational read port.
// Ports: clk; we (byte enables), waddr, wdata (write port);
//        raddr (read set), rdata (line at raddr, combinational).
module mike_data_bank #(
  parameter int unsigned s_index = 3,
  parameter int unsigned s_mask  = 32,
  localparam int unsigned s_line   = 8 * s_mask,
  localparam int unsigned num_sets = 2 ** s_index
) (
  input  logic                clk,
  input  logic [s_mask-1:0]   we,
  input  logic [s_index-1:0]  waddr,
  input  logic [s_line-1:0]   wdata,
  input  logic [s_index-1:0]  raddr,
  output logic [s_line-1:0]   rdata
);

  logic [s_line-1:0] mem [num_sets];

  // Byte-masked write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(s_mask); b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mike_wayed_data_array.sv
// Multi-way cache data store: byte-masked CPU writes, registered read port
// with per-byte write-first forwarding, and a burst line-fill engine.
// Optional macro MIKE_DATA_ARRAY_RESET_CLEAR_EN: reset sweeps every set to zero.
// Ports:
//   clk, rst (sync, active high)
//   rd_valid/rd_way/rd_index -> rd_data/rd_data_valid (1-cycle latency)
//   wr_en/wr_way/wr_index/wr_data: CPU byte write, accepted only when idle
//   fill_start/fill_way/fill_index, fill_beat_valid/fill_beat_data: line fill
//   fill_done: pulse after last beat; busy: fill or clear in progress
module mike_wayed_data_array
  import mike_cache_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 2,
  parameter int unsigned s_beat   = 64,
  localparam int unsigned s_mask  = mask_bits(s_offset),
  localparam int unsigned s_line  = line_bits(s_offset),
  localparam int unsigned s_way   = $clog2(num_ways)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_valid,
  input  logic [s_way-1:0]   rd_way,
  input  logic [s_index-1:0] rd_index,
  output logic [s_line-1:0]  rd_data,
  output logic               rd_data_valid,
  input  logic [s_mask-1:0]  wr_en,
  input  logic [s_way-1:0]   wr_way,
  input  logic [s_index-1:0] wr_index,
  input  logic [s_line-1:0]  wr_data,
  input  logic               fill_start,
  input  logic [s_way-1:0]   fill_way,
  input  logic [s_index-1:0] fill_index,
  input  logic               fill_beat_valid,
  input  logic [s_beat-1:0]  fill_beat_data,
  output logic               fill_done,
  output logic               busy
);

  localparam int unsigned num_sets   = 2 ** s_index;
  localparam int unsigned num_beats  = s_line / s_beat;
  localparam int unsigned s_cnt      = $clog2(num_beats);
  localparam int unsigned beat_bytes = s_beat / 8;
  localparam logic [s_mask-1:0] beat_mask = s_mask'({beat_bytes{1'b1}});

  logic [1:0]         state, state_next;
  logic [s_cnt-1:0]   cnt, cnt_next;
  logic [s_way-1:0]   fway, fway_next;
  logic [s_index-1:0] findex, findex_next;
  logic               done_next;
`ifdef MIKE_DATA_ARRAY_RESET_CLEAR_EN
  logic [s_index-1:0] clr_cnt, clr_cnt_next;
`endif

  // Single write descriptor shared by CPU, fill and clear (never concurrent).
  logic [s_mask-1:0]  w_mask;
  logic [s_way-1:0]   w_way;
  logic [s_index-1:0] w_index;
  logic [s_line-1:0]  w_data;
  logic               w_all;

  logic [s_line-1:0]  bank_rdata [num_ways];
  logic [s_line-1:0]  rd_line;

  // Next-state and write-port selection.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    fway_next   = fway;
    findex_next = findex;
    done_next   = 1'b0;
    w_mask      = '0;
    w_way       = wr_way;
    w_index     = wr_index;
    w_data      = wr_data;
    w_all       = 1'b0;
`ifdef MIKE_DATA_ARRAY_RESET_CLEAR_EN
    clr_cnt_next = clr_cnt;
`endif
    case (state)
      ST_IDLE: begin
        w_mask = wr_en;
        if (fill_start) begin
          state_next  = ST_FILL;
          fway_next   = fill_way;
          findex_next = fill_index;
          cnt_next    = '0;
        end
      end
      ST_FILL: begin
        if (fill_beat_valid) begin
          // Beat is replicated across the line; the mask picks its slot.
          w_mask   = beat_mask << (cnt * beat_bytes);
          w_way    = fway;
          w_index  = findex;
          w_data   = {num_beats{fill_beat_data}};
          cnt_next = cnt + 1'b1;
          if (cnt == s_cnt'(num_beats - 1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
`ifdef MIKE_DATA_ARRAY_RESET_CLEAR_EN
      ST_CLEAR: begin
        w_mask       = '1;
        w_all        = 1'b1;
        w_index      = clr_cnt;
        w_data       = '0;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == s_index'(num_sets - 1)) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
    // No array update on a reset cycle; the clear sweep starts afterwards.
    if (rst) w_mask = '0;
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MIKE_DATA_ARRAY_RESET_CLEAR_EN
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
`else
      state   <= ST_IDLE;
      busy    <= 1'b0;
`endif
      cnt       <= '0;
      fway      <= '0;
      findex    <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      fway      <= fway_next;
      findex    <= findex_next;
      fill_done <= done_next;
      busy      <= (state_next != ST_IDLE);
`ifdef MIKE_DATA_ARRAY_RESET_CLEAR_EN
      clr_cnt   <= clr_cnt_next;
`endif
    end
  end

  // Way storage.
  for (genvar g = 0; g < int'(num_ways); g++) begin : g_way
    logic [s_mask-1:0] bank_we;
    assign bank_we = (w_all || (w_way == s_way'(g))) ? w_mask : '0;
    mike_data_bank #(
      .s_index (s_index),
      .s_mask  (s_mask)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (w_index),
      .wdata (w_data),
      .raddr (rd_index),
      .rdata (bank_rdata[g])
    );
  end

  // Write-first forwarding per byte.
  always_comb begin
    rd_line = bank_rdata[rd_way];
    for (int b = 0; b < int'(s_mask); b++) begin
      if (w_mask[b] && (w_all || (w_way == rd_way)) && (w_index == rd_index))
        rd_line[8*b +: 8] = w_data[8*b +: 8];
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else if (rd_valid && (state != ST_CLEAR)) begin
      rd_data       <= rd_line;
      rd_data_valid <= 1'b1;
    end else begin
      rd_data_valid <= 1'b0;
    end
  end

endmodule
